// File: rtl/rv32_fetch_pkg.sv
// Shared constants, fetch-state encoding and helpers for the RV32IM fetch stage.
package rv32_fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK      = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC selection: redirect target beats sequential advance, which beats hold.
module pc_next_sel
  import rv32_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  input  logic        redirect_i,
  input  logic        advance_i,
  output logic [31:0] pc_next_o
);

  // NOTE: every path through this block assigns pc_next_o, so no latch is inferred.
  always_comb begin
    if (redirect_i) begin
      pc_next_o = align_word(target_i);
    end else if (advance_i) begin
      pc_next_o = pc_i + PC_INC;
    end else begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory reads and presents the
// IF/ID payload, with a one-entry skid buffer for stalls and redirect squashing.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = rv32_fetch_pkg::DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = rv32_fetch_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PC_REDIRECT,
  input  logic [31:0] REDIRECT_TARGET,
  input  logic        STALL,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_READDATA,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID
);

  import rv32_fetch_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  discard_addr_q;
  logic         if_valid_q;
  logic [31:0]  if_pc_q, if_instr_q;
  logic [31:0]  skid_pc_q, skid_instr_q;
  logic         imem_read;
  logic         access_done;
  logic         advance;

  assign imem_read   = (state_q == FETCH) || (state_q == DISCARD);
  assign access_done = imem_read && !IMEM_BUSYWAIT;
  assign advance     = (state_q == FETCH) && access_done;

  pc_next_sel u_pc_next_sel (
    .pc_i       (pc_q),
    .target_i   (REDIRECT_TARGET),
    .redirect_i (PC_REDIRECT),
    .advance_i  (advance),
    .pc_next_o  (pc_d)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the skid entry is a handful of flops, not a RAM, so resetting it is free and keeps it X-clean.
      state_q        <= IDLE;
      pc_q           <= RESET_VECTOR;
      discard_addr_q <= RESET_VECTOR;
      if_valid_q     <= 1'b0;
      if_pc_q        <= RESET_VECTOR;
      if_instr_q     <= NOP_INSTR;
      skid_pc_q      <= RESET_VECTOR;
      skid_instr_q   <= NOP_INSTR;
    end else begin
      pc_q <= pc_d;
      if (PC_REDIRECT) begin
        if_valid_q <= 1'b0;
        if_instr_q <= NOP_INSTR;
        // A still-busy access cannot be withdrawn; ride it out at the old address.
        if (imem_read && IMEM_BUSYWAIT) begin
          state_q <= DISCARD;
          if (state_q == FETCH) discard_addr_q <= pc_q;
        end else begin
          state_q <= FETCH;
        end
      end else begin
        case (state_q)
          IDLE: state_q <= FETCH;
          FETCH: begin
            if (STALL) begin
              if (access_done) begin
                skid_pc_q    <= pc_q;
                skid_instr_q <= IMEM_READDATA;
                state_q      <= HOLD;
              end
            end else if (access_done) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_instr_q <= IMEM_READDATA;
            end else begin
              if_valid_q <= 1'b0;
              if_instr_q <= NOP_INSTR;
            end
          end
          HOLD: begin
            if (!STALL) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= skid_pc_q;
              if_instr_q <= skid_instr_q;
              state_q    <= FETCH;
            end
          end
          DISCARD: begin
            if (!STALL) begin
              if_valid_q <= 1'b0;
              if_instr_q <= NOP_INSTR;
            end
            if (access_done) state_q <= FETCH;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign IMEM_READ = imem_read;
  assign IMEM_ADDR = (state_q == DISCARD) ? discard_addr_q : pc_q;
  assign IF_VALID  = if_valid_q;
  assign IF_PC     = if_pc_q;
  assign IF_PC4    = if_pc_q + PC_INC;
  assign IF_INSTR  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a default-vector instance for the pipeline
// scenarios and a second instance near the top of memory for wrap and async reset.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WRAPV = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect, busy;
  logic [31:0] target;
  logic        imem_read, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_pc4, if_instr;

  logic        w_rst_n, w_busy;
  logic        w_stall    = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_target   = 32'h0;
  logic        w_read, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_pc4, w_instr;

  exp_t        sb_q[$];
  logic [31:0] wq[$];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = tag(imem_addr);
  assign w_rdata    = tag(w_addr);

  pc_fetch_unit dut (
    .CLK(clk), .RESET_N(rst_n), .PC_REDIRECT(redirect), .REDIRECT_TARGET(target),
    .STALL(stall), .IMEM_READ(imem_read), .IMEM_ADDR(imem_addr),
    .IMEM_BUSYWAIT(busy), .IMEM_READDATA(imem_rdata), .IF_PC(if_pc),
    .IF_PC4(if_pc4), .IF_INSTR(if_instr), .IF_VALID(if_valid)
  );

  pc_fetch_unit #(.RESET_VECTOR(WRAPV)) dut_w (
    .CLK(clk), .RESET_N(w_rst_n), .PC_REDIRECT(w_redirect), .REDIRECT_TARGET(w_target),
    .STALL(w_stall), .IMEM_READ(w_read), .IMEM_ADDR(w_addr),
    .IMEM_BUSYWAIT(w_busy), .IMEM_READDATA(w_rdata), .IF_PC(w_pc),
    .IF_PC4(w_pc4), .IF_INSTR(w_instr), .IF_VALID(w_valid)
  );

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = tag(a);
    sb_q.push_back(e);
  endtask

  // One clock of stimulus; any newly presented instruction is matched against the scoreboard.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic bz);
    exp_t e;
    stall = st; redirect = rd; target = tgt; busy = bz;
    @(posedge clk); #1;
    if (!st && if_valid) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: presented pc=%h instr=%h, expected nothing", if_pc, if_instr);
      end else begin
        e = sb_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr || if_pc4 !== e.pc + 32'd4)
          $display("FAIL sb_present: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                   if_pc, if_instr, if_pc4, e.pc, e.instr, e.pc + 32'd4);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (imem_read !== 1'b0) $display("FAIL reset_read: got %b want 0", imem_read); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else n_pass++;
    n_total++; if (if_instr !== NOP) $display("FAIL reset_instr: got %h want %h", if_instr, NOP); else n_pass++;
    n_total++; if (if_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", if_pc); else n_pass++;
    n_total++; if (if_pc4 !== 32'h4) $display("FAIL reset_pc4: got %h want 4", if_pc4); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (imem_read !== 1'b0) $display("FAIL idle_read: got %b want 0", imem_read); else n_pass++;
  endtask

  task automatic test_sequential();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_total++; if (imem_read !== 1'b1) $display("FAIL seq_first_read: got %b want 1", imem_read); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL seq_first_valid: got %b want 0", if_valid); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (imem_addr !== 32'(i * 4)) $display("FAIL seq_addr: got %h want %h", imem_addr, 32'(i * 4));
      else n_pass++;
      push(32'(i * 4));
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_busywait();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (imem_addr !== 32'h8 || imem_read !== 1'b1)
        $display("FAIL busy_addr: got read=%b addr=%h want read=1 addr=8", imem_read, imem_addr);
      else n_pass++;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n_total++;
      if (if_valid !== 1'b0 || if_instr !== NOP)
        $display("FAIL busy_bubble: got valid=%b instr=%h want valid=0 instr=%h", if_valid, if_instr, NOP);
      else n_pass++;
    end
    n_total++; if (imem_addr !== 32'h8) $display("FAIL busy_addr_last: got %h want 8", imem_addr); else n_pass++;
    push(32'h8);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_total++; if (imem_addr !== 32'hC) $display("FAIL busy_next_addr: got %h want c", imem_addr); else n_pass++;
  endtask

  task automatic test_stall();
    push(32'hC);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== tag(32'h8))
        $display("FAIL stall_frozen: got valid=%b pc=%h instr=%h want valid=1 pc=8 instr=%h",
                 if_valid, if_pc, if_instr, tag(32'h8));
      else n_pass++;
      n_total++; if (imem_read !== 1'b0) $display("FAIL hold_read: got %b want 0", imem_read); else n_pass++;
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_total++;
    if (imem_read !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL stall_resume: got read=%b addr=%h want read=1 addr=10", imem_read, imem_addr);
    else n_pass++;
    push(32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_redirect_discard();
    n_total++; if (imem_addr !== 32'h14) $display("FAIL disc_pre_addr: got %h want 14", imem_addr); else n_pass++;
    step(1'b0, 1'b1, 32'h100, 1'b1);
    n_total++;
    if (imem_read !== 1'b1 || imem_addr !== 32'h14 || if_valid !== 1'b0)
      $display("FAIL disc_enter: got read=%b addr=%h valid=%b want read=1 addr=14 valid=0",
               imem_read, imem_addr, if_valid);
    else n_pass++;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++; if (imem_addr !== 32'h14) $display("FAIL disc_hold_addr: got %h want 14", imem_addr); else n_pass++;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_total++;
    if (if_valid !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL disc_exit: got valid=%b read=%b addr=%h want valid=0 read=1 addr=100",
               if_valid, imem_read, imem_addr);
    else n_pass++;
    push(32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_redirect_stall();
    step(1'b1, 1'b1, 32'h203, 1'b0);
    n_total++; if (if_valid !== 1'b0) $display("FAIL rs_valid: got %b want 0", if_valid); else n_pass++;
    n_total++;
    if (imem_read !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL rs_addr: got read=%b addr=%h want read=1 addr=200", imem_read, imem_addr);
    else n_pass++;
    push(32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    push(32'h204);
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_wrap_and_async_reset();
    logic [31:0] a;
    logic [31:0] e;
    w_rst_n = 1'b1;
    @(posedge clk); #1;
    a = WRAPV;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (w_addr !== a) $display("FAIL wrap_addr: got %h want %h", w_addr, a); else n_pass++;
      wq.push_back(a);
      a = a + 32'd4;
      @(posedge clk); #1;
      e = wq.pop_front();
      n_total++;
      if (w_valid !== 1'b1 || w_pc !== e || w_instr !== tag(e) || w_pc4 !== e + 32'd4)
        $display("FAIL wrap_present: got valid=%b pc=%h instr=%h pc4=%h want valid=1 pc=%h instr=%h pc4=%h",
                 w_valid, w_pc, w_instr, w_pc4, e, tag(e), e + 32'd4);
      else n_pass++;
    end
    w_busy = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (w_read !== 1'b1 || w_addr !== 32'h4)
      $display("FAIL wrap_pending: got read=%b addr=%h want read=1 addr=4", w_read, w_addr);
    else n_pass++;
    #2;
    w_rst_n = 1'b0;
    #1;
    n_total++;
    if (w_read !== 1'b0 || w_valid !== 1'b0 || w_addr !== WRAPV || w_instr !== NOP)
      $display("FAIL async_reset: got read=%b valid=%b addr=%h instr=%h want read=0 valid=0 addr=%h instr=%h",
               w_read, w_valid, w_addr, w_instr, WRAPV, NOP);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b1; w_rst_n = 1'b1;
    stall = 1'b0; redirect = 1'b0; target = 32'h0; busy = 1'b0; w_busy = 1'b0;
    #1;
    rst_n = 1'b0; w_rst_n = 1'b0;
    test_reset();
    test_sequential();
    test_busywait();
    test_stall();
    test_redirect_discard();
    test_redirect_stall();
    test_wrap_and_async_reset();
    n_total++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries still expected, want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
